serial_addsub_seq: RTL and testbench

Byte-serial multi-word add/subtract sequencer for the convolution datapath (partial-sum and bias arithmetic).
- Reuses a single 8-bit add/sub slice over BYTES cycles to produce a BYTES*8-bit result.
- Carry/borrow is chained through an internal register.
- Valid/ready handshakes on input and output let it sit between accumulator stages of the systolic array.

---
 rtl/serial_addsub_seq.sv | 105 ++++++++++
 tb/tb_serial_addsub_seq.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub_seq.sv
// serial_addsub_seq: byte-serial W-bit add/subtract through one 8-bit slice, valid/ready on both sides.
// Define SERIAL_ADDSUB_SAT_EN to saturate the unsigned result when entering DONE.
module serial_addsub_seq #(
    parameter int BYTES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 op_sub,
    input  logic [8*BYTES-1:0]   op_a,
    input  logic [8*BYTES-1:0]   op_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*BYTES-1:0]   out_sum,
    output logic                 out_carry,
    output logic                 out_ovf
);
    localparam int W = 8 * BYTES;
    localparam int CW = BYTES > 1 ? $clog2(BYTES) : 1;
    localparam logic [CW-1:0] LAST = CW'(BYTES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic            sub_q, sub_d, carry_q, carry_d, cy_q, cy_d, ovf_q, ovf_d;
    logic [7:0]      a_k, b_k, s_k;
    logic            c_out;

    always_comb begin
        a_k = '0;
        b_k = '0;
        for (int i = 0; i < BYTES; i++)
            if (cnt_q == CW'(i)) begin
                a_k = a_q[8*i +: 8];
                b_k = b_q[8*i +: 8] ^ {8{sub_q}};
            end
        {c_out, s_k} = {1'b0, a_k} + {1'b0, b_k} + {8'd0, carry_q};
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sub_d   = sub_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cy_d    = cy_q;
        ovf_d   = ovf_q;
        if (state_q == IDLE && in_valid) begin
            a_d     = op_a;
            b_d     = op_b;
            sub_d   = op_sub;
            carry_d = op_sub;
            cnt_d   = '0;
            state_d = RUN;
        end else if (state_q == RUN) begin
            carry_d = c_out;
            cnt_d   = cnt_q == LAST ? '0 : cnt_q + CW'(1);
            for (int i = 0; i < BYTES; i++)
                if (cnt_q == CW'(i)) sum_d[8*i +: 8] = s_k;
            if (cnt_q == LAST) begin
                state_d = DONE;
                cy_d    = c_out ^ sub_q;
                // carry into the MSB is recovered from the top bit's sum and inputs
                ovf_d   = c_out ^ a_k[7] ^ b_k[7] ^ s_k[7];
`ifdef SERIAL_ADDSUB_SAT_EN
                if (cy_d) sum_d = sub_q ? '0 : '1;
`endif
            end
        end else if (state_q == DONE && out_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cy_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cy_q    <= cy_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign out_sum   = sum_q;
    assign out_carry = cy_q;
    assign out_ovf   = ovf_q;
endmodule

// File: tb/tb_serial_addsub_seq.sv
// tb_serial_addsub_seq: vector table plus hand sequences (backpressure, mid-run reset) against a result queue.
// Saturated expectations are applied when SERIAL_ADDSUB_SAT_EN is defined.
module tb_serial_addsub_seq;
    localparam int BYTES = 4;
    localparam int W = 8 * BYTES;

    typedef struct {
        logic         sub;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] sum;
        logic         c;
        logic         o;
    } vec_t;

    typedef struct {
        logic [W-1:0] sum;
        logic         c;
        logic         o;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, op_sub, out_valid, out_ready, out_carry, out_ovf;
    logic [W-1:0] op_a, op_b, out_sum;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    vec_t tbl[12];

    serial_addsub_seq #(.BYTES(BYTES)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op_sub(op_sub), .op_a(op_a), .op_b(op_b), .out_valid(out_valid),
        .out_ready(out_ready), .out_sum(out_sum), .out_carry(out_carry), .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input vec_t v);
        exp_t e;
        e.sum = v.sum;
        e.c   = v.c;
        e.o   = v.o;
`ifdef SERIAL_ADDSUB_SAT_EN
        if (v.c) e.sum = v.sub ? '0 : '1;
`endif
        return e;
    endfunction

    task automatic start(input vec_t v, input bit push);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        op_sub   = v.sub;
        op_a     = v.a;
        op_b     = v.b;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", 64'(n < 40), 64'(1));
        if (push) q.push_back(mk(v));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op_sub   = ~v.sub;
        op_a     = ~v.a;
        op_b     = ~v.b;
    endtask

    task automatic wait_valid();
        int lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 40);
        chk("latency", 64'(lat - 1), 64'(BYTES));
    endtask

    task automatic cmp_out(input string tag);
        if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s unexpected result actual=%0h required=none", tag, out_sum);
        end else begin
            chk({tag, "_sum"}, 64'(out_sum), 64'(q[0].sum));
            chk({tag, "_carry"}, 64'(out_carry), 64'(q[0].c));
            chk({tag, "_ovf"}, 64'(out_ovf), 64'(q[0].o));
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        if (q.size() != 0) void'(q.pop_front());
        chk("valid_drop", 64'(out_valid), 64'(0));
        chk("ready_back", 64'(in_ready), 64'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1'b0, 32'h000000FF, 32'h00000001, 32'h00000100, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1};
        tbl[3]  = '{1'b1, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 32'h00000001, 32'h00000002, 32'hFFFFFFFF, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 32'h12345678, 32'h87654321, 32'h99999999, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1};
        tbl[10] = '{1'b1, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b1, 1'b1};
        tbl[11] = '{1'b0, 32'h00FF00FF, 32'h00010001, 32'h01000100, 1'b0, 1'b0};

        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        op_sub = 1'b0;
        op_a = '0;
        op_b = '0;
        #1;
        chk("rst_valid", 64'(out_valid), 64'(0));
        chk("rst_sum", 64'(out_sum), 64'(0));
        chk("rst_carry", 64'(out_carry), 64'(0));
        chk("rst_ovf", 64'(out_ovf), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_ready", 64'(in_ready), 64'(1));

        for (int i = 0; i < 12; i++) begin
            start(tbl[i], 1'b1);
            // odd vectors hold out_ready high through RUN, which must be ignored
            if (i % 2 == 1) out_ready = 1'b1;
            wait_valid();
            cmp_out($sformatf("vec%0d", i));
            handshake();
        end

        start('{1'b0, 32'h00000001, 32'h00000002, 32'h00000003, 1'b0, 1'b0}, 1'b1);
        wait_valid();
        cmp_out("bp_first");
        in_valid = 1'b1;
        op_sub   = 1'b0;
        op_a     = 32'h00000010;
        op_b     = 32'h00000020;
        q.push_back(mk('{1'b0, 32'h00000010, 32'h00000020, 32'h00000030, 1'b0, 1'b0}));
        for (int k = 0; k < 3; k++) begin
            chk("bp_valid", 64'(out_valid), 64'(1));
            chk("bp_in_ready", 64'(in_ready), 64'(0));
            chk("bp_sum", 64'(out_sum), 64'(32'h00000003));
            chk("bp_carry", 64'(out_carry), 64'(0));
            @(negedge clk);
        end
        handshake();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_held_accept", 64'(in_ready), 64'(0));
        wait_valid();
        cmp_out("bp_second");
        handshake();

        start('{1'b1, 32'h00000100, 32'h00000001, 32'h000000FF, 1'b0, 1'b0}, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_valid", 64'(out_valid), 64'(0));
        chk("abort_sum", 64'(out_sum), 64'(0));
        chk("abort_carry", 64'(out_carry), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("abort_ready", 64'(in_ready), 64'(1));
        start('{1'b0, 32'h00000010, 32'h00000020, 32'h00000030, 1'b0, 1'b0}, 1'b1);
        wait_valid();
        cmp_out("post_reset");
        handshake();

        chk("queue_empty", 64'(q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
